// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage TSC pipeline: load-use and RAW stalls, predict-not-taken
// redirects, HLT drain and freeze, retired-instruction count. Optional macro: FORWARDING_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal fetch/issue, hazard and redirect priorities active
// DRAIN  | HLT accepted in ID, fetch blocked, older work flows to WB
// HALTED | HLT retired, every pipeline register and the PC frozen
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic [1:0]       ID_rs,
    input  logic [1:0]       ID_rt,
    input  logic             ID_Halt,
    input  logic             ID_jump,
    input  logic             EX_branch_taken,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [1:0]       EX_reg_write_addr,
    input  logic             MEM_RegWrite,
    input  logic [1:0]       MEM_reg_write_addr,
    input  logic             WB_Halt,
    output logic             pc_stall,
    output logic [1:0]       pc_sel,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halt,
    output logic             is_halted,
    output logic [CNT_W-1:0] num_inst
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             v_id, v_ex, v_mem, v_wb;
    logic [CNT_W-1:0] cnt_q;

    logic             load_en;
    logic             hz;
    logic             br_flush;
    logic             enter_drain;

    logic             pc_stall_c;
    logic [1:0]       pc_sel_c;
    logic             if_id_stall_c;
    logic             if_id_flush_c;
    logic             id_ex_bubble_c;
    logic             halt_c;
    logic             is_halted_c;

    function automatic logic src_hit(input logic       use_s,
                                     input logic [1:0] s,
                                     input logic       wr_en,
                                     input logic [1:0] wr_addr);
        return use_s & wr_en & (s == wr_addr);
    endfunction

    assign load_en = v_ex & EX_RegWrite & EX_MemRead;

`ifdef FORWARDING_EN
    // MEM destination is only needed for stall detection when nothing forwards.
    logic unused_mem;
    assign unused_mem = ^{MEM_RegWrite, MEM_reg_write_addr};

    assign hz = v_id & (src_hit(ID_use_rs, ID_rs, load_en, EX_reg_write_addr) |
                        src_hit(ID_use_rt, ID_rt, load_en, EX_reg_write_addr));
`else
    logic ex_en;
    logic mem_en;
    assign ex_en  = v_ex & EX_RegWrite;
    assign mem_en = v_mem & MEM_RegWrite;

    assign hz = v_id & (src_hit(ID_use_rs, ID_rs, load_en, EX_reg_write_addr) |
                        src_hit(ID_use_rt, ID_rt, load_en, EX_reg_write_addr) |
                        src_hit(ID_use_rs, ID_rs, ex_en,   EX_reg_write_addr) |
                        src_hit(ID_use_rt, ID_rt, ex_en,   EX_reg_write_addr) |
                        src_hit(ID_use_rs, ID_rs, mem_en,  MEM_reg_write_addr) |
                        src_hit(ID_use_rt, ID_rt, mem_en,  MEM_reg_write_addr));
`endif

    assign br_flush    = EX_branch_taken & v_ex;
    assign enter_drain = (state == RUN) & v_id & ID_Halt & ~hz & ~br_flush;

    always_comb begin
        state_nxt      = state;
        pc_stall_c     = 1'b0;
        pc_sel_c       = 2'd0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        halt_c         = 1'b0;
        is_halted_c    = 1'b0;
        case (state)
            RUN: begin
                if (br_flush) begin
                    pc_sel_c       = 2'd2;
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (hz) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (ID_jump && v_id) begin
                    pc_sel_c      = 2'd1;
                    if_id_flush_c = 1'b1;
                end
                if (enter_drain) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                if (v_wb && WB_Halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                pc_stall_c  = 1'b1;
                halt_c      = 1'b1;
                is_halted_c = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RUN;
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (!halt_c) begin
                v_wb  <= v_mem;
                v_mem <= v_ex;
                v_ex  <= v_id & ~id_ex_bubble_c;
                v_id  <= if_id_stall_c ? v_id
                                       : (~if_id_flush_c & (state == RUN) & ~enter_drain);
            end
            // The HLT itself counts on the DRAIN->HALTED edge; nothing counts once frozen.
            if (v_wb && (state != HALTED)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_stall     = reset_n & pc_stall_c;
    assign pc_sel       = reset_n ? pc_sel_c : 2'd0;
    assign if_id_stall  = reset_n & if_id_stall_c;
    assign if_id_flush  = reset_n & if_id_flush_c;
    assign id_ex_bubble = reset_n & id_ex_bubble_c;
    assign halt         = reset_n & halt_c;
    assign is_halted    = reset_n & is_halted_c;
    assign num_inst     = reset_n ? cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; expected control words and counts are hand-derived
// per cycle, with the FORWARDING_EN build selecting the forwarding-dependent expectations.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // control word order: {pc_stall, pc_sel[1:0], if_id_stall, if_id_flush, id_ex_bubble, halt, is_halted}
    localparam logic [7:0] C_ZERO   = 8'b0_00_0_0_0_0_0;
    localparam logic [7:0] C_STALL  = 8'b1_00_1_0_1_0_0;
    localparam logic [7:0] C_BRANCH = 8'b0_10_0_1_1_0_0;
    localparam logic [7:0] C_JUMP   = 8'b0_01_0_1_0_0_0;
    localparam logic [7:0] C_DRAIN  = 8'b1_00_0_1_0_0_0;
    localparam logic [7:0] C_HALTED = 8'b1_00_0_0_0_1_1;

`ifdef FORWARDING_EN
    localparam logic [7:0] C_FWD_DEP = C_ZERO;
    localparam int         ALU_STALLS = 0;
`else
    localparam logic [7:0] C_FWD_DEP = C_STALL;
    localparam int         ALU_STALLS = 2;
`endif

    logic             clk;
    logic             reset_n;
    logic             ID_use_rs, ID_use_rt;
    logic [1:0]       ID_rs, ID_rt;
    logic             ID_Halt, ID_jump;
    logic             EX_branch_taken, EX_RegWrite, EX_MemRead;
    logic [1:0]       EX_reg_write_addr;
    logic             MEM_RegWrite;
    logic [1:0]       MEM_reg_write_addr;
    logic             WB_Halt;
    logic             pc_stall;
    logic [1:0]       pc_sel;
    logic             if_id_stall, if_id_flush, id_ex_bubble, halt, is_halted;
    logic [CNT_W-1:0] num_inst;
    logic [7:0]       ctl;

    int n_vec = 0;
    int n_err = 0;
    int stalls;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ID_use_rs          (ID_use_rs),
        .ID_use_rt          (ID_use_rt),
        .ID_rs              (ID_rs),
        .ID_rt              (ID_rt),
        .ID_Halt            (ID_Halt),
        .ID_jump            (ID_jump),
        .EX_branch_taken    (EX_branch_taken),
        .EX_RegWrite        (EX_RegWrite),
        .EX_MemRead         (EX_MemRead),
        .EX_reg_write_addr  (EX_reg_write_addr),
        .MEM_RegWrite       (MEM_RegWrite),
        .MEM_reg_write_addr (MEM_reg_write_addr),
        .WB_Halt            (WB_Halt),
        .pc_stall           (pc_stall),
        .pc_sel             (pc_sel),
        .if_id_stall        (if_id_stall),
        .if_id_flush        (if_id_flush),
        .id_ex_bubble       (id_ex_bubble),
        .halt               (halt),
        .is_halted          (is_halted),
        .num_inst           (num_inst)
    );

    assign ctl = {pc_stall, pc_sel, if_id_stall, if_id_flush, id_ex_bubble, halt, is_halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        ID_use_rs          = 1'b0;
        ID_use_rt          = 1'b0;
        ID_rs              = 2'd0;
        ID_rt              = 2'd0;
        ID_Halt            = 1'b0;
        ID_jump            = 1'b0;
        EX_branch_taken    = 1'b0;
        EX_RegWrite        = 1'b0;
        EX_MemRead         = 1'b0;
        EX_reg_write_addr  = 2'd0;
        MEM_RegWrite       = 1'b0;
        MEM_reg_write_addr = 2'd0;
        WB_Halt            = 1'b0;
    endtask

    // Leaves the bench at the negedge just after reset release (all valid bits clear).
    task automatic do_reset();
        reset_n = 1'b0;
        clr_in();
        ID_jump = 1'b1; ID_Halt = 1'b1; EX_branch_taken = 1'b1; WB_Halt = 1'b1;
        #1;
        chk_val("rst_ctl", ctl, C_ZERO);
        chk_val("rst_cnt", num_inst, 0);
        tick();
        clr_in();
        reset_n = 1'b1;
        ID_jump = 1'b1; EX_branch_taken = 1'b1;
        #1;
        chk_val("rel_ctl", ctl, C_ZERO);
        chk_val("rel_cnt", num_inst, 0);
        clr_in();
    endtask

    initial begin
        reset_n = 1'b0;
        clr_in();
        @(negedge clk);
        do_reset();

        // load-use: LWD $1 ; ADD $2,$1,$1
        tick();
        ID_use_rs = 1'b1; ID_rs = 2'd0;
        #1 chk_val("lu_lwd_id", ctl, C_ZERO);
        tick();
        ID_use_rs = 1'b1; ID_use_rt = 1'b1; ID_rs = 2'd1; ID_rt = 2'd1;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_reg_write_addr = 2'd1;
        #1 chk_val("lu_stall", ctl, C_STALL);
        tick();
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_reg_write_addr = 2'd0;
        MEM_RegWrite = 1'b1; MEM_reg_write_addr = 2'd1;
        #1 chk_val("lu_2nd", ctl, C_FWD_DEP);
        tick();
        MEM_RegWrite = 1'b0; MEM_reg_write_addr = 2'd0;
        #1 chk_val("lu_free", ctl, C_ZERO);
        tick();
        clr_in();
        tick();
        #1 chk_val("lu_cnt_p6", num_inst, 1);
        tick();
`ifdef FORWARDING_EN
        #1 chk_val("lu_cnt_p7", num_inst, 2);
        tick();
        #1 chk_val("lu_cnt_p8", num_inst, 3);
`else
        #1 chk_val("lu_cnt_p7", num_inst, 1);
        tick();
        #1 chk_val("lu_cnt_p8", num_inst, 2);
`endif

        // taken branch in EX beats load-use, jump and HLT in ID
        do_reset();
        tick();
        #1 chk_val("br_id", ctl, C_ZERO);
        tick();
        EX_branch_taken = 1'b1; EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_reg_write_addr = 2'd1;
        ID_Halt = 1'b1; ID_jump = 1'b1; ID_use_rs = 1'b1; ID_rs = 2'd1;
        #1 chk_val("br_flush", ctl, C_BRANCH);
        tick();
        clr_in();
        ID_jump = 1'b1; EX_branch_taken = 1'b1;
        #1 chk_val("br_still_run", ctl, C_ZERO);
        tick();
        clr_in();
        tick();
        #1 chk_val("br_cnt_p5", num_inst, 1);
        tick();
        tick();
        #1 chk_val("br_cnt_p7", num_inst, 1);
        tick();
        #1 chk_val("br_cnt_p8", num_inst, 2);

        // JPR $1 in ID while LWD $1 is in EX
        do_reset();
        tick();
        ID_use_rs = 1'b1; ID_rs = 2'd0;
        tick();
        ID_jump = 1'b1; ID_use_rs = 1'b1; ID_rs = 2'd1;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_reg_write_addr = 2'd1;
        #1 chk_val("jmp_stall", ctl, C_STALL);
        tick();
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_reg_write_addr = 2'd0;
        MEM_RegWrite = 1'b1; MEM_reg_write_addr = 2'd1;
`ifndef FORWARDING_EN
        #1 chk_val("jmp_stall2", ctl, C_STALL);
        tick();
        MEM_RegWrite = 1'b0; MEM_reg_write_addr = 2'd0;
`endif
        #1 chk_val("jmp_redirect", ctl, C_JUMP);
        tick();
        clr_in();
        ID_jump = 1'b1;
        #1 chk_val("jmp_flushed", ctl, C_ZERO);
        clr_in();

        // 5 ALU ops then HLT: drain, halt, freeze
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1 chk_val("alu_run", ctl, C_ZERO);
        end
        tick();
        ID_Halt = 1'b1;
        #1 chk_val("hlt_in_id", ctl, C_ZERO);
        tick();
        clr_in();
        #1 chk_val("drain_p7", ctl, C_DRAIN);
        chk_val("drain_cnt_p7", num_inst, 3);
        tick();
        #1 chk_val("drain_p8", ctl, C_DRAIN);
        tick();
        WB_Halt = 1'b1;
        #1 chk_val("drain_p9", ctl, C_DRAIN);
        chk_val("drain_cnt_p9", num_inst, 5);
        tick();
        #1 chk_val("halted_ctl", ctl, C_HALTED);
        chk_val("halted_cnt", num_inst, 6);
        ID_jump = 1'b1; EX_branch_taken = 1'b1; ID_Halt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            #1 chk_val("hold_ctl", ctl, C_HALTED);
            chk_val("hold_cnt", num_inst, 6);
        end
        clr_in();

        // reset while draining with num_inst=3
        do_reset();
        for (int k = 1; k <= 3; k++) tick();
        tick();
        ID_Halt = 1'b1;
        tick();
        clr_in();
        tick();
        tick();
        #1 chk_val("rd_drain", ctl, C_DRAIN);
        chk_val("rd_cnt", num_inst, 3);
        reset_n = 1'b0;
        WB_Halt = 1'b1;
        #1 chk_val("rd_in_rst", ctl, C_ZERO);
        chk_val("rd_cnt_rst", num_inst, 0);
        tick();
        reset_n = 1'b1;
        #1 chk_val("rd_run", ctl, C_ZERO);
        chk_val("rd_cnt_run", num_inst, 0);
        clr_in();

        // ADD $1 ; ADD $2,$1,$1 (stalls only without forwarding)
        do_reset();
        stalls = 0;
        tick();
        tick();
        ID_use_rs = 1'b1; ID_use_rt = 1'b1; ID_rs = 2'd1; ID_rt = 2'd1;
        EX_RegWrite = 1'b1; EX_reg_write_addr = 2'd1;
        #1 chk_val("alu_dep_ex", ctl, C_FWD_DEP);
        stalls += int'(pc_stall);
        tick();
        EX_RegWrite = 1'b0; EX_reg_write_addr = 2'd0;
        MEM_RegWrite = 1'b1; MEM_reg_write_addr = 2'd1;
        #1 chk_val("alu_dep_mem", ctl, C_FWD_DEP);
        stalls += int'(pc_stall);
        tick();
        MEM_RegWrite = 1'b0; MEM_reg_write_addr = 2'd0;
        #1 chk_val("alu_dep_free", ctl, C_ZERO);
        stalls += int'(pc_stall);
        chk_val("alu_dep_stalls", stalls, ALU_STALLS);
        clr_in();

        // counter wraps modulo 2^CNT_W
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 20) chk_val("wrap_p20", num_inst, 0);
        end
        #1 chk_val("wrap_p21", num_inst, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
